// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit two's-complement subtractor (diff = a - b), LSB first, start/busy/done handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_step;
    logic             w_last;

    // Minuend register doubles as the result shift register: sum bits enter at the MSB
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_a_bit;
    logic             w_nb_bit;
    logic             w_sum;
    logic             w_cout;

    assign w_a_bit  = r_a[0];
    assign w_nb_bit = ~r_b[0];
    assign w_sum    = w_a_bit ^ w_nb_bit ^ r_carry;
    assign w_cout   = (w_a_bit & w_nb_bit) | (w_a_bit & r_carry) | (w_nb_bit & r_carry);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and step controls
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_count == CW'(WIDTH - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand shifting, carry chain and registered handshake/result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_busy <= (w_state_next == S_RUN);
            r_done <= (w_state_next == S_DONE);
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= 1'b1;
                r_count <= '0;
            end else if (w_step) begin
                r_a     <= {w_sum, r_a[WIDTH-1:1]};
                r_b     <= {1'b0, r_b[WIDTH-1:1]};
                r_carry <= w_cout;
                r_count <= r_count + CW'(1);
            end
            if (w_last) begin
                r_diff   <= {w_sum, r_a[WIDTH-1:1]};
                r_borrow <= ~w_cout;
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_overflow;

    // On the MSB step r_carry is the carry into the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_last) begin
            r_overflow <= r_carry ^ w_cout;
        end
    end

    assign overflow = r_overflow;
`endif

    assign busy   = r_busy;
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4) with hand-computed results.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow;
`endif

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] last_diff = '0;
    int done_cnt;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .borrow  (borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow(overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ovf(input string tag, input logic exp);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk(tag, 32'(overflow), 32'(exp));
`endif
    endtask

    // Launch one operation and walk the full busy/done timeline; operand inputs are scrambled after acceptance
    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta;
        b = ~tb_v;
        for (int i = 0; i < int'(WIDTH); i++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            chk({tag, "_held"}, 32'(diff), 32'(last_diff));
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
        chk_ovf({tag, "_ovf"}, eo);
        @(negedge clk);
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_diff_kept"}, 32'(diff), 32'(ed));
        last_diff = ed;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk_ovf("rst_ovf", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("op5m9", 4'b0101, 4'b1001, 4'b1100, 1'b1, 1'b1);
        run_op("opffff", 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);
        run_op("op0mf", 4'b0000, 4'b1111, 4'b0001, 1'b1, 1'b0);
        run_op("op8m1", 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1);

        // start raised mid-run with different operands must be ignored
        a = 4'b0011;
        b = 4'b0001;
        start = 1'b1;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a = 4'b1111;
        b = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                done_cnt++;
                chk("mid_diff", 32'(diff), 32'b0010);
                chk("mid_borrow", 32'(borrow), 32'd0);
            end
            @(negedge clk);
        end
        chk("mid_one_done", 32'(done_cnt), 32'd1);
        chk("mid_idle", 32'(busy), 32'd0);

        // reset two bits into an operation aborts it without a done pulse
        a = 4'b0110;
        b = 4'b0010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        last_diff = '0;
        run_op("op6m2", 4'b0110, 4'b0010, 4'b0100, 1'b0, 1'b0);

        // continuous start: RUN x4, DONE, accepting IDLE, repeat every 6 cycles
        a = 4'b0111;
        b = 4'b0010;
        start = 1'b1;
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            chk("hold_busy", 32'(busy), 32'((j % 6) < 4));
            chk("hold_done", 32'(done), 32'((j % 6) == 4));
            if ((j % 6) == 4) begin
                chk("hold_diff", 32'(diff), 32'b0101);
                chk("hold_borrow", 32'(borrow), 32'd0);
            end
        end
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
